sr_latch_bank: RTL
==================

# sr_latch_bank

Clocked, parametrised bank of set/reset flags for the microwave controller's level-3 control path (door, start, stop, fault flags). Each channel takes active-low set/reset requests with SR-latch idle semantics (both high = hold), filters them for a configurable number of stable cycles, and resolves them per a selectable mode. Each channel drives registered Q/Q_bar and a one-cycle change pulse. The block replaces free-running cross-coupled latches with fully synchronous, glitch-filtered state.

## Interface
- CHANNELS, 4: number of independent flag channels (1–16).
- FILTER_CYCLES, 3: consecutive identical samples required before a command is applied (1–15).
- MODE, 0: both-asserted resolution. 0 = reset-dominant, 1 = set-dominant, 2 = toggle, 3 = hold.
- INIT, '0: CHANNELS-bit reset value of q.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- s_n  in  CHANNELS  per-channel set request, active-low.
- r_n  in  CHANNELS  per-channel reset request, active-low.
- q  out  CHANNELS  flag state, registered.
- q_bar  out  CHANNELS  always ~q, registered.
- changed  out  CHANNELS  one-cycle pulse, high in the cycle q[i] takes a new value.
- invalid  out  1  sticky: some channel had both inputs qualified-asserted.

## Operation
- Per-channel command: cmd = {~s_n[i], ~r_n[i]}. Values are NONE 00, RST 01, SET 10, BOTH 11.
- Inputs are captured in a sample register each edge. This is the only synchronisation; inputs are treated as asynchronous.
- A per-channel filter counter tracks consecutive equal samples. Any differing sample restarts the count at 1 with the new candidate.
- When the count reaches FILTER_CYCLES, the candidate is qualified. The counter saturates and holds until the sample changes.
- Qualified SET → q=1. Qualified RST → q=0. Qualified NONE → hold.
- Qualified BOTH by MODE:
  - 0 → q=0.
  - 1 → q=1.
  - 2 → q toggles exactly once per qualification event. A held BOTH does not re-toggle; it must drop and re-qualify.
  - 3 → hold.
- SET/RST are level-applied and idempotent while held.
- changed[i] is asserted only if the new q differs from the old q. Re-applying the same value gives no pulse.
- invalid is set on any qualified BOTH in any channel. It clears only on reset.
- Channels are fully independent, and simultaneous events on different channels are all honoured in the same cycle.

## Timing
- Reset (rst_n=0 at an edge): q=INIT, q_bar=~INIT, changed=0, invalid=0. Sample registers are loaded with NONE and counters with 0.
- Reset overrides every other event in the same edge. A partially filtered command is discarded; after release it needs a full FILTER_CYCLES of samples again.
- Latency: input stable before edge k is sampled at edge k, and q/q_bar/changed update at edge k+FILTER_CYCLES. With FILTER_CYCLES=1, q updates at edge k+1.
- A pulse shorter than FILTER_CYCLES sampled cycles is ignored entirely and q is unchanged.
- A command changing directly from SET to RST restarts filtering; there is no intermediate NONE requirement.
- changed is high for exactly one cycle per transition. Back-to-back transitions (toggle re-qualified) may pulse on consecutive qualifications.
- Counter width is $clog2(FILTER_CYCLES+1) bits. The counter never wraps.

## Configuration
- SR_LATCH_BANK_INVALID_EN
  - Defined: the invalid detection logic and sticky register are built as described.
  - Undefined: invalid is tied to 0 and no detection logic is generated. MODE behaviour for BOTH is unchanged.

## Structure
- Package sr_bank_pkg:
  - mode constants SR_MODE_RST_DOM=0, SR_MODE_SET_DOM=1, SR_MODE_TOGGLE=2, SR_MODE_HOLD=3;
  - the 2-bit command typedef with NONE/RST/SET/BOTH encodings.
- Sub-module sr_bank_channel: sample register, filter counter, resolution logic and changed generation for one channel. It also outputs a per-channel both_qualified flag.
- The top instantiates CHANNELS copies in a generate loop and ORs the both_qualified flags into the sticky invalid register.

## Test plan
- Reset with INIT=4'b1010, then release with all inputs high → q=1010, q_bar=0101, changed=0, invalid=0, held for 20 cycles.
- FILTER_CYCLES=3: s_n[0] low for 2 cycles then high → q[0] unchanged, no changed pulse. s_n[0] low for 3 cycles → q[0]=1 at the 3rd sampling edge, changed[0] high for exactly that cycle.
- MODE=2: s_n[1] and r_n[1] low for 10 cycles → q[1] toggles once. Release, then re-assert for 3 cycles → q[1] toggles back. invalid=1 and stays high.
- MODE=0 vs MODE=1: hold both inputs of channel 2 low with q[2] preset to 1 → q[2]=0 in MODE 0, stays 1 in MODE 1 with no changed pulse.
- Simultaneous: SET on channel 0 and RST on channel 3 qualify on the same edge → both q bits and both changed bits update together.
- Reset mid-filter: r_n[0] low for 2 cycles, rst_n low one edge, r_n held low → q[0] changes only 3 cycles after reset release. Without SR_LATCH_BANK_INVALID_EN, invalid stays 0 throughout the BOTH scenarios.

Source files
------------

// File: rtl/sr_bank_pkg.sv
// sr_bank_pkg
//   Shared definitions for the set/reset flag bank: the mode constants that
//   pick how a qualified "both asserted" command resolves, and the 2-bit
//   command encoding built from the active-low set/reset request pair.
package sr_bank_pkg;

  localparam int SR_MODE_RST_DOM = 0;  // BOTH forces q=0
  localparam int SR_MODE_SET_DOM = 1;  // BOTH forces q=1
  localparam int SR_MODE_TOGGLE  = 2;  // BOTH flips q once per qualification
  localparam int SR_MODE_HOLD    = 3;  // BOTH leaves q alone

  // {set, reset} after inversion of the active-low inputs.
  typedef enum logic [1:0] {
    CMD_NONE = 2'b00,
    CMD_RST  = 2'b01,
    CMD_SET  = 2'b10,
    CMD_BOTH = 2'b11
  } sr_cmd_e;

endpackage

// File: rtl/sr_bank_channel.sv
// sr_bank_channel
//   One flag channel: samples the asynchronous active-low set/reset pair,
//   filters it for FILTER_CYCLES consecutive equal samples, resolves the
//   qualified command per MODE and drives registered q / q_bar plus a
//   one-cycle change pulse.
//   Optional build macro SR_LATCH_BANK_INVALID_EN adds the both_qualified_o
//   port, flagging a qualified BOTH command this cycle.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   s_n_i, r_n_i      set / reset request, active-low, asynchronous
//   q_o, q_bar_o      registered flag state and its complement
//   changed_o         high for the cycle in which q_o took a new value
//   both_qualified_o  (macro only) qualified BOTH in this cycle
module sr_bank_channel
  import sr_bank_pkg::*;
#(
  parameter int   FILTER_CYCLES = 3,
  parameter int   MODE          = SR_MODE_RST_DOM,
  parameter logic INIT_BIT      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s_n_i,
  input  logic r_n_i,
  output logic q_o,
  output logic q_bar_o,
  output logic changed_o
`ifdef SR_LATCH_BANK_INVALID_EN
  ,
  output logic both_qualified_o
`endif
);

  localparam int             CW      = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(FILTER_CYCLES);

  sr_cmd_e       samp_q, samp_d;   // synchroniser stage, the only use of raw inputs
  sr_cmd_e       cand_q, cand_d;   // candidate being filtered
  logic [CW-1:0] cnt_q, cnt_d;     // consecutive equal samples of cand
  logic          q_q, q_d;
  logic          q_bar_q;
  logic          changed_q, changed_d;
  logic          qual;             // candidate is qualified this edge
  logic          fresh;            // qualification is a new event, not a held one

  always_comb begin
    samp_d = sr_cmd_e'({~s_n_i, ~r_n_i});
    cand_d = samp_q;
    // The filter runs on the registered sample stream only, so a metastable
    // raw input never reaches the counter or the resolution logic.
    if ((cnt_q != '0) && (samp_q == cand_q)) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end else begin
      cnt_d = CW'(1);
    end
    qual  = (cnt_d == CNT_MAX);
    // Already saturated on the same candidate means the command is merely
    // being held; toggle mode must not act again on that.
    fresh = qual && !((cnt_q == CNT_MAX) && (samp_q == cand_q));

    q_d = q_q;
    if (qual) begin
      case (cand_d)
        CMD_SET: q_d = 1'b1;
        CMD_RST: q_d = 1'b0;
        CMD_BOTH: begin
          if (MODE == SR_MODE_RST_DOM) begin
            q_d = 1'b0;
          end else if (MODE == SR_MODE_SET_DOM) begin
            q_d = 1'b1;
          end else if ((MODE == SR_MODE_TOGGLE) && fresh) begin
            q_d = ~q_q;
          end
        end
        default: q_d = q_q;
      endcase
    end
    changed_d = q_d ^ q_q;
  end

`ifdef SR_LATCH_BANK_INVALID_EN
  assign both_qualified_o = qual && (cand_d == CMD_BOTH);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      samp_q    <= CMD_NONE;
      cand_q    <= CMD_NONE;
      cnt_q     <= '0;
      q_q       <= INIT_BIT;
      q_bar_q   <= ~INIT_BIT;
      changed_q <= 1'b0;
    end else begin
      samp_q    <= samp_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      q_bar_q   <= ~q_d;
      changed_q <= changed_d;
    end
  end

  assign q_o       = q_q;
  assign q_bar_o   = q_bar_q;
  assign changed_o = changed_q;

endmodule

// File: rtl/sr_latch_bank.sv
// sr_latch_bank
//   Bank of CHANNELS independent, glitch-filtered synchronous set/reset flags
//   with a sticky "both asserted" indicator.
//   Optional build macro SR_LATCH_BANK_INVALID_EN: when defined, the sticky
//   invalid register and its detection are built; otherwise invalid is 0.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   s_n, r_n     per-channel set / reset requests, active-low
//   q, q_bar     registered flag state and complement
//   changed      per-channel one-cycle pulse on a q transition
//   invalid      sticky: some channel qualified BOTH since reset
module sr_latch_bank
  import sr_bank_pkg::*;
#(
  parameter int                  CHANNELS      = 4,
  parameter int                  FILTER_CYCLES = 3,
  parameter int                  MODE          = SR_MODE_RST_DOM,
  parameter logic [CHANNELS-1:0] INIT          = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] s_n,
  input  logic [CHANNELS-1:0] r_n,
  output logic [CHANNELS-1:0] q,
  output logic [CHANNELS-1:0] q_bar,
  output logic [CHANNELS-1:0] changed,
  output logic                invalid
);

`ifdef SR_LATCH_BANK_INVALID_EN
  logic [CHANNELS-1:0] both_qualified;
`endif

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    sr_bank_channel #(
      .FILTER_CYCLES (FILTER_CYCLES),
      .MODE          (MODE),
      .INIT_BIT      (INIT[gi])
    ) u_channel (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_n_i     (s_n[gi]),
      .r_n_i     (r_n[gi]),
      .q_o       (q[gi]),
      .q_bar_o   (q_bar[gi]),
      .changed_o (changed[gi])
`ifdef SR_LATCH_BANK_INVALID_EN
      ,
      .both_qualified_o (both_qualified[gi])
`endif
    );
  end

`ifdef SR_LATCH_BANK_INVALID_EN
  logic invalid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      invalid_q <= 1'b0;
    end else if (|both_qualified) begin
      invalid_q <= 1'b1;
    end
  end

  assign invalid = invalid_q;
`else
  assign invalid = 1'b0;
`endif

endmodule
